// File: rtl/regfile_2r1w_bypass.sv
// Purpose: 32 x WIDTH register file, two combinational read ports, one write port,
//          optional same-cycle write-to-read forwarding; register 0 is hard-wired to zero.
// Latency: reads are zero-cycle (combinational); writes are visible after the rising edge.
// Backpressure: none; every write with RegWrite=1 is accepted on the edge it is presented.
// Ports:
//   clk, reset          - single clock, synchronous active-high reset (clears r1..r31)
//   RegWrite            - write enable
//   WriteRegister/Data  - write address (0 discards) and data
//   ReadRegister1/2     - read addresses
//   ReadData1/2         - read data (0 for address 0)
module regfile_2r1w_bypass #(
    parameter int WIDTH  = 32,
    parameter int BYPASS = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             RegWrite,
    input  logic [4:0]       WriteRegister,
    input  logic [WIDTH-1:0] WriteData,
    input  logic [4:0]       ReadRegister1,
    input  logic [4:0]       ReadRegister2,
    output logic [WIDTH-1:0] ReadData1,
    output logic [WIDTH-1:0] ReadData2
);

    // Only r1..r31 carry state; r0 is synthesised away as constant zero.
    logic [WIDTH-1:0] r_regs [1:31];

    logic             w_wr_en;
    logic             w_fwd_en;
    logic [WIDTH-1:0] w_stored1;
    logic [WIDTH-1:0] w_stored2;

    assign w_wr_en = RegWrite && (WriteRegister != 5'd0);

    // Forwarding is blocked during reset so reads show stored contents until the clearing edge.
    assign w_fwd_en = (BYPASS != 0) && w_wr_en && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[WriteRegister] <= WriteData;
        end
    end

    always_comb begin
        w_stored1 = '0;
        w_stored2 = '0;
        if (ReadRegister1 != 5'd0) begin
            w_stored1 = r_regs[ReadRegister1];
        end
        if (ReadRegister2 != 5'd0) begin
            w_stored2 = r_regs[ReadRegister2];
        end
    end

    always_comb begin
        ReadData1 = w_stored1;
        ReadData2 = w_stored2;
        // Address 0 never matches a live write (w_wr_en excludes it), so r0 stays zero.
        if (w_fwd_en && (ReadRegister1 == WriteRegister)) begin
            ReadData1 = WriteData;
        end
        if (w_fwd_en && (ReadRegister2 == WriteRegister)) begin
            ReadData2 = WriteData;
        end
    end

endmodule

// File: tb/tb_regfile_2r1w_bypass.sv
// Purpose: self-checking bench for regfile_2r1w_bypass, forwarding and non-forwarding builds.
// Latency: model compared every falling edge; inputs change 1 time unit after the rising edge.
// Backpressure: not applicable.
module tb_regfile_2r1w_bypass;

    logic        clk;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [31:0] rd1_byp, rd2_byp, rd1_nob, rd2_nob;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: plain array of register values plus a "has been reset" flag.
    logic [31:0] model_mem [32];
    bit          model_valid = 0;

    regfile_2r1w_bypass #(.WIDTH(32), .BYPASS(1)) dut_byp (
        .clk(clk), .reset(reset), .RegWrite(RegWrite),
        .WriteRegister(WriteRegister), .WriteData(WriteData),
        .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .ReadData1(rd1_byp), .ReadData2(rd2_byp)
    );

    regfile_2r1w_bypass #(.WIDTH(32), .BYPASS(0)) dut_nob (
        .clk(clk), .reset(reset), .RegWrite(RegWrite),
        .WriteRegister(WriteRegister), .WriteData(WriteData),
        .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .ReadData1(rd1_nob), .ReadData2(rd2_nob)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected read value from the register-file rules.
    function automatic logic [31:0] model_rd(input bit byp, input logic [4:0] ra);
        if (ra == 5'd0) return 32'h0;
        if (byp && !reset && RegWrite && WriteRegister != 5'd0 && WriteRegister == ra)
            return WriteData;
        return model_mem[ra];
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) model_mem[i] = 32'h0;
            model_valid = 1;
        end else if (RegWrite && WriteRegister != 5'd0) begin
            model_mem[WriteRegister] = WriteData;
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            chk("model_byp_rd1", rd1_byp, model_rd(1'b1, ReadRegister1));
            chk("model_byp_rd2", rd2_byp, model_rd(1'b1, ReadRegister2));
            chk("model_nob_rd1", rd1_nob, model_rd(1'b0, ReadRegister1));
            chk("model_nob_rd2", rd2_nob, model_rd(1'b0, ReadRegister2));
        end
    end

    // Apply a vector just after the rising edge, then settle to mid-cycle for literal checks.
    task automatic apply(input logic rst, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [4:0] ra1, input logic [4:0] ra2);
        @(posedge clk);
        #1;
        reset = rst; RegWrite = we; WriteRegister = wa; WriteData = wd;
        ReadRegister1 = ra1; ReadRegister2 = ra2;
        @(negedge clk);
        #1;
    endtask

    initial begin
        reset = 1; RegWrite = 0; WriteRegister = 0; WriteData = 0;
        ReadRegister1 = 0; ReadRegister2 = 0;

        // Reset one cycle, then sweep every address on both ports.
        apply(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 32; i++) begin
            apply(0, 0, 0, 0, 5'(i), 5'(31 - i));
            chk("reset_sweep_byp_rd1", rd1_byp, 32'h0);
            chk("reset_sweep_byp_rd2", rd2_byp, 32'h0);
            chk("reset_sweep_nob_rd1", rd1_nob, 32'h0);
        end

        // Write r5 then read on both ports; neighbours stay zero.
        apply(0, 1, 5, 32'hDEADBEEF, 4, 6);
        apply(0, 0, 0, 0, 5, 5);
        chk("r5_port1", rd1_nob, 32'hDEADBEEF);
        chk("r5_port2", rd2_nob, 32'hDEADBEEF);
        chk("r5_byp_same", rd1_byp, rd2_nob);
        apply(0, 0, 0, 0, 4, 6);
        chk("r4_zero", rd1_byp, 32'h0);
        chk("r6_zero", rd2_byp, 32'h0);

        // Write to r0 is discarded, even with forwarding enabled.
        apply(0, 1, 0, 32'hFFFFFFFF, 0, 0);
        chk("r0_during_write", rd1_byp, 32'h0);
        apply(0, 0, 0, 0, 0, 0);
        chk("r0_after_write", rd2_byp, 32'h0);

        // Forwarding vs. pre-edge value on r7.
        apply(0, 1, 7, 32'h1, 0, 0);
        apply(0, 1, 7, 32'h2, 7, 7);
        chk("byp_r7_same_cycle", rd1_byp, 32'h2);
        chk("nob_r7_same_cycle", rd1_nob, 32'h1);
        apply(0, 0, 0, 0, 7, 7);
        chk("byp_r7_after", rd1_byp, 32'h2);
        chk("nob_r7_after", rd1_nob, 32'h2);

        // RegWrite=0 leaves r9 alone.
        apply(0, 0, 9, 32'h55, 9, 9);
        apply(0, 0, 0, 0, 9, 9);
        chk("r9_no_write", rd1_byp, 32'h0);

        // Back-to-back writes to r3, last write wins; concurrent write to r10 while reading r11.
        apply(0, 1, 3, 32'h11, 11, 3);
        apply(0, 1, 3, 32'h22, 11, 3);
        chk("nob_r3_first", rd2_nob, 32'h11);
        apply(0, 1, 10, 32'hCAFE0000, 11, 3);
        chk("r11_unaffected", rd1_byp, 32'h0);
        chk("r3_last_wins", rd2_nob, 32'h22);

        // Reset beats a simultaneous write; stored data readable while reset is high.
        apply(0, 1, 31, 32'h1234, 0, 0);
        apply(1, 1, 31, 32'hA5A5A5A5, 31, 10);
        chk("reset_hold_byp_r31", rd1_byp, 32'h1234);
        chk("reset_hold_nob_r31", rd1_nob, 32'h1234);
        chk("reset_hold_r10", rd2_byp, 32'hCAFE0000);
        apply(0, 1, 31, 32'hA5A5A5A5, 31, 10);
        chk("post_reset_byp_fwd", rd1_byp, 32'hA5A5A5A5);
        chk("post_reset_nob_r31", rd1_nob, 32'h0);
        chk("post_reset_r10", rd2_nob, 32'h0);
        apply(0, 0, 0, 0, 31, 31);
        chk("r31_written", rd1_nob, 32'hA5A5A5A5);
        chk("r31_port2", rd2_byp, 32'hA5A5A5A5);

        @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_2r1w_bypass.md
REGFILE_2R1W_BYPASS -- requirements
Module: regfile_2r1w_bypass

Interface
REQ-001 Parameter WIDTH, default 32, data width of each register and of every data port.
REQ-002 Parameter BYPASS, default 1; 1 enables write-to-read forwarding, 0 disables it.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 RegWrite  input  1  write enable for the write port.
REQ-007 WriteRegister  input  5  write address, 0..31.
REQ-008 WriteData  input  WIDTH  data to write.
REQ-009 ReadRegister1  input  5  read port 1 address.
REQ-010 ReadRegister2  input  5  read port 2 address.
REQ-011 ReadData1  output  WIDTH  read port 1 data.
REQ-012 ReadData2  output  WIDTH  read port 2 data.

Function
REQ-013 Storage SHALL be 32 registers x WIDTH bits; register 0 holds no state.
REQ-014 Write: on rising clk edge with reset=0 and RegWrite=1 and WriteRegister!=0, register[WriteRegister] SHALL take WriteData; no other register changes.
REQ-015 RegWrite=0 SHALL leave every register unchanged; WriteRegister and WriteData are don't-care.
REQ-016 WriteRegister=0 with RegWrite=1 SHALL be discarded silently; register 0 keeps reading 0.
REQ-017 Reads SHALL be combinational, zero-cycle latency: ReadDataN = register[ReadRegisterN], selected via a 32:1 WIDTH-bit selection per port.
REQ-018 ReadRegisterN=0 SHALL yield ReadDataN=0 regardless of any write or bypass.
REQ-019 Both read ports SHALL be independent; identical addresses on both ports SHALL return identical data.
REQ-020 BYPASS=1: when RegWrite=1, WriteRegister!=0, reset=0 and ReadRegisterN==WriteRegister, ReadDataN SHALL equal WriteData in the same cycle (before the edge).
REQ-021 BYPASS=0: ReadDataN SHALL show the pre-edge stored value during the write cycle and the new value only after the edge.
REQ-022 Bypass SHALL be suppressed while reset=1; ReadDataN then shows stored contents.
REQ-023 Back-to-back writes to the same register on consecutive edges SHALL each take effect; last write wins.
REQ-024 Write and read of different addresses in the same cycle SHALL not interact.
REQ-025 Only stored-state elements: 31 x WIDTH registers; no latches, no combinational loops.

Reset
REQ-026 On rising clk edge with reset=1, all registers 1..31 SHALL clear to 0; reset has priority over a simultaneous write.
REQ-027 After reset, ReadData1 and ReadData2 SHALL be 0 for every address until a write occurs.
REQ-028 Asserting reset mid-operation SHALL clear state at that edge only; contents before the edge remain readable while reset is high.
REQ-029 Deasserting reset SHALL permit a write on the very next edge.

Verification
REQ-030 Reset 1 cycle, then read all 32 addresses on both ports -> all 0.
REQ-031 Write 0xDEADBEEF to r5, next cycle read r5 on port1 and port2 -> both 0xDEADBEEF; r4, r6 -> 0.
REQ-032 RegWrite=1, WriteRegister=0, WriteData=0xFFFFFFFF, then read r0 -> 0.
REQ-033 BYPASS=1: r7=0x1; same cycle write 0x2 to r7 with ReadRegister1=7 -> ReadData1=0x2 before edge; BYPASS=0 -> 0x1 before edge, 0x2 after.
REQ-034 RegWrite=0 with WriteRegister=9, WriteData=0x55 -> r9 unchanged (0 after reset).
REQ-035 Write 0xA5A5A5A5 to r31 with reset=1 on same edge -> r31 reads 0; next cycle write with reset=0 -> r31 reads 0xA5A5A5A5.
